// File: rtl/blockram_tx_streamer_if.sv
// Handshake and bus signals between the TX streamer, its controller, the message RAM
// and the UART transmitter.
interface blockram_tx_streamer_if #(
    parameter int unsigned ADDR_BITS = 7,
    parameter int unsigned LEN_BITS  = 9
);
    logic                 start;
    logic [ADDR_BITS-1:0] base_addr;
    logic [LEN_BITS-1:0]  byte_count;
    logic                 busy;
    logic                 done;
    logic                 mem_read_en;
    logic [ADDR_BITS-1:0] mem_raddr;
    logic [31:0]          mem_rdata;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    // Environment side: controller, RAM data return and UART ready.
    modport master (
        output start, base_addr, byte_count, mem_rdata, tx_ready,
        input  busy, done, mem_read_en, mem_raddr, tx_data, tx_valid
    );

    modport slave (
        input  start, base_addr, byte_count, mem_rdata, tx_ready,
        output busy, done, mem_read_en, mem_raddr, tx_data, tx_valid
    );
endinterface

// File: rtl/blockram_tx_streamer.sv
// Streams a run of 32-bit message-RAM words to the UART TX as bytes, LSB first.
// One RAM read per word; 2 dead cycles (fetch + load) between words.
module blockram_tx_streamer #(
    parameter int unsigned ADDR_BITS = 7,
    parameter int unsigned LEN_BITS  = 9
) (
    input logic                    clk,
    input logic                    rst,
    blockram_tx_streamer_if.slave  bus
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StSend,
        StFinish
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [LEN_BITS-1:0]  remaining_q, remaining_d;
    logic [2:0]           lanes_q, lanes_d;
    logic [31:0]          shift_q, shift_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 rd_en_q, rd_en_d;
    logic [ADDR_BITS-1:0] raddr_q, raddr_d;
    logic                 tx_valid_q, tx_valid_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        lanes_d     = lanes_q;
        shift_d     = shift_q;
        raddr_d     = raddr_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.byte_count != '0) begin
                        addr_d      = bus.base_addr;
                        remaining_d = bus.byte_count;
                        state_d     = StFetch;
                    end else begin
                        state_d = StFinish;
                    end
                end
            end
            StFetch: state_d = StLoad;
            StLoad: begin
                shift_d = bus.mem_rdata;
                lanes_d = (remaining_q >= LEN_BITS'(4)) ? 3'd4 : remaining_q[2:0];
                addr_d  = addr_q + ADDR_BITS'(1);
                state_d = StSend;
            end
            StSend: begin
                if (tx_valid_q && bus.tx_ready) begin
                    shift_d     = {8'h00, shift_q[31:8]};
                    remaining_d = remaining_q - LEN_BITS'(1);
                    lanes_d     = lanes_q - 3'd1;
                    if (remaining_q == LEN_BITS'(1)) begin
                        state_d = StFinish;
                    end else if (lanes_q == 3'd1) begin
                        state_d = StFetch;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        // Outputs are registered from the next state so they line up with the state register.
        busy_d     = (state_d != StIdle);
        done_d     = (state_d == StFinish);
        rd_en_d    = (state_d == StFetch);
        tx_valid_d = (state_d == StSend);
        if (state_d == StFetch) begin
            raddr_d = addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            lanes_q     <= '0;
            shift_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            raddr_q     <= '0;
            tx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            lanes_q     <= lanes_d;
            shift_q     <= shift_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            raddr_q     <= raddr_d;
            tx_valid_q  <= tx_valid_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.mem_read_en = rd_en_q;
    assign bus.mem_raddr   = raddr_q;
    assign bus.tx_valid    = tx_valid_q;
    // The low byte of the shift register is the byte on offer; it only moves on a handshake.
    assign bus.tx_data     = shift_q[7:0];

endmodule
